// File: rtl/arith_pkg.sv
// Shared definitions for the add/sub arbiter slice.
//   DEF_WIDTH       default operand/result width
//   ALU_ADD/ALU_SUB per-client mode encoding seen by the ALU
//   arb_state_e     arbiter FSM states
package arith_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  localparam logic ALU_ADD = 1'b1;
  localparam logic ALU_SUB = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/addsub_arbiter_rr_if.sv
// Client-side bus of the shared add/sub front-end.
//   req_i   per-client level request, held until own ready_o pulse
//   mode_i  per-client op (1=add, 0=sub a-b)
//   a_i/b_i flattened operands, client k at [k*WIDTH +: WIDTH]
//   ready_o one-hot single-cycle pulse marking res_o valid for that client
//   res_o   registered result shared by all clients
// master: client side, slave: arbiter side.
interface addsub_arbiter_rr_if
  import arith_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned WIDTH     = DEF_WIDTH
);

  logic [N_CLIENTS-1:0]       req_i;
  logic [N_CLIENTS-1:0]       mode_i;
  logic [N_CLIENTS*WIDTH-1:0] a_i;
  logic [N_CLIENTS*WIDTH-1:0] b_i;
  logic [N_CLIENTS-1:0]       ready_o;
  logic [WIDTH-1:0]           res_o;

  modport master (
    output req_i, mode_i, a_i, b_i,
    input  ready_o, res_o
  );

  modport slave (
    input  req_i, mode_i, a_i, b_i,
    output ready_o, res_o
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational masked round-robin selector.
//   req  request vector
//   mask requesters excluded from this pick
//   ptr  highest-priority index; search runs ptr, ptr+1, .. mod N_CLIENTS
//   any  at least one eligible requester
//   idx  index of the first eligible requester in search order
module rr_pick #(
  parameter  int unsigned N_CLIENTS = 4,
  localparam int unsigned IDX_W     = $clog2(N_CLIENTS)
) (
  input  logic [N_CLIENTS-1:0] req,
  input  logic [N_CLIENTS-1:0] mask,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 any,
  output logic [IDX_W-1:0]     idx
);

  logic [N_CLIENTS-1:0] elig;
  int unsigned          k;

  assign elig = req & ~mask;

  always_comb begin
    any = 1'b0;
    idx = '0;
    k   = 0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      // ptr < N_CLIENTS, so a single subtraction performs the wrap
      k = 32'(ptr) + i;
      if (k >= N_CLIENTS) begin
        k = k - N_CLIENTS;
      end
      if (!any && elig[k]) begin
        any = 1'b1;
        idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter_rr.sv
// Round-robin front-end sharing one combinational add/sub ALU between
// N_CLIENTS iterative units. Operands are latched at grant, the ALU sees only
// the latched op, and the result is returned registered with a one-hot
// ready pulse. Sustains one op every two clocks under back-to-back load.
//   clk_i, rst_i  clock, asynchronous active-low reset
//   cli           client bus (req/mode/a/b in, ready/res out)
//   alu_mode_o, alu_a_o, alu_b_o  latched op to the ALU
//   alu_res_i     ALU result, same cycle
//   busy_o        high while an op is in ISSUE or RESP
// Optional: define ARB_STATS_EN to add ops_cnt_o[31:0] (completed ops) and
// conflict_cnt_o[15:0] (arbitrations with >=2 eligible requesters), both
// saturating.
module addsub_arbiter_rr
  import arith_pkg::*;
#(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned WIDTH     = DEF_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  addsub_arbiter_rr_if.slave cli,
  output logic               alu_mode_o,
  output logic [WIDTH-1:0]   alu_a_o,
  output logic [WIDTH-1:0]   alu_b_o,
  input  logic [WIDTH-1:0]   alu_res_i,
  output logic               busy_o
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]        ops_cnt_o,
  output logic [15:0]        conflict_cnt_o
`endif
);

  localparam int unsigned IDX_W = $clog2(N_CLIENTS);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gnt_q, gnt_d;
  logic                 op_mode_q, op_mode_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [N_CLIENTS-1:0] ready_q, ready_d;

  logic [N_CLIENTS-1:0] gnt_onehot;
  logic [N_CLIENTS-1:0] pick_mask;
  logic                 pick_any;
  logic [IDX_W-1:0]     pick_idx;
  logic [WIDTH-1:0]     a_arr [N_CLIENTS];
  logic [WIDTH-1:0]     b_arr [N_CLIENTS];

  always_comb begin
    for (int unsigned k = 0; k < N_CLIENTS; k++) begin
      a_arr[k] = cli.a_i[k*WIDTH +: WIDTH];
      b_arr[k] = cli.b_i[k*WIDTH +: WIDTH];
    end
  end

  assign gnt_onehot = N_CLIENTS'(1) << gnt_q;
  // In RESP the just-served client still holds req for this cycle
  assign pick_mask  = (state_q == RESP) ? gnt_onehot : '0;

  rr_pick #(
    .N_CLIENTS(N_CLIENTS)
  ) u_pick (
    .req (cli.req_i),
    .mask(pick_mask),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    op_mode_d = op_mode_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    ready_d   = '0;
    unique case (state_q)
      IDLE, RESP: begin
        if (pick_any) begin
          gnt_d     = pick_idx;
          op_mode_d = cli.mode_i[pick_idx];
          op_a_d    = a_arr[pick_idx];
          op_b_d    = b_arr[pick_idx];
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        res_d   = alu_res_i;
        ready_d = gnt_onehot;
        ptr_d   = (gnt_q == IDX_W'(N_CLIENTS - 1)) ? '0 : gnt_q + IDX_W'(1);
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      op_mode_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      ready_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      op_mode_q <= op_mode_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      res_q     <= res_d;
      ready_q   <= ready_d;
    end
  end

  assign cli.ready_o = ready_q;
  assign cli.res_o   = res_q;
  assign alu_mode_o  = op_mode_q;
  assign alu_a_o     = op_a_q;
  assign alu_b_o     = op_b_q;
  assign busy_o      = (state_q != IDLE);

`ifdef ARB_STATS_EN
  logic [N_CLIENTS-1:0] elig;
  logic                 contended;

  assign elig      = cli.req_i & ~pick_mask;
  // more than one bit set: clearing the lowest set bit leaves something
  assign contended = (elig & (elig - N_CLIENTS'(1))) != '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ops_cnt_o      <= '0;
      conflict_cnt_o <= '0;
    end else begin
      if ((state_q == ISSUE) && (ops_cnt_o != '1)) begin
        ops_cnt_o <= ops_cnt_o + 32'd1;
      end
      if ((state_q != ISSUE) && pick_any && contended && (conflict_cnt_o != '1)) begin
        conflict_cnt_o <= conflict_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_addsub_arbiter_rr.sv
`timescale 1ns/1ps
module tb_addsub_arbiter_rr;
  import arith_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         alu_mode_o;
  logic [W-1:0] alu_a_o, alu_b_o, alu_res_i;
  logic         busy_o;
`ifdef ARB_STATS_EN
  logic [31:0]  ops_cnt_o;
  logic [15:0]  conflict_cnt_o;
`endif

  addsub_arbiter_rr_if #(.N_CLIENTS(N), .WIDTH(W)) cli ();

  addsub_arbiter_rr #(.N_CLIENTS(N), .WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cli       (cli),
    .alu_mode_o(alu_mode_o),
    .alu_a_o   (alu_a_o),
    .alu_b_o   (alu_b_o),
    .alu_res_i (alu_res_i),
    .busy_o    (busy_o)
`ifdef ARB_STATS_EN
    ,
    .ops_cnt_o     (ops_cnt_o),
    .conflict_cnt_o(conflict_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // the shared ALU
  assign alu_res_i = (alu_mode_o == ALU_ADD) ? alu_a_o + alu_b_o : alu_a_o - alu_b_o;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int           m_ptr, m_cli, m_excl, m_win, m_cnt;
  bit           m_inflight, m_resp;
  logic [N-1:0] e_ready;
  logic [W-1:0] e_res, e_a, e_b;
  logic         e_mode;
  longint       e_ops, e_conf;

  function automatic int rr_choose(logic [N-1:0] r, int excl, int p);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (p + i) % N;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  task automatic model_step();
    if (!rst_i) begin
      m_ptr = 0; m_cli = 0; m_inflight = 0; m_resp = 0;
      e_ready = '0; e_res = '0; e_a = '0; e_b = '0; e_mode = 1'b0;
      e_ops = 0; e_conf = 0;
    end else if (m_inflight) begin
      e_res      = e_mode ? W'(e_a + e_b) : W'(e_a - e_b);
      e_ready    = '0;
      e_ready[m_cli] = 1'b1;
      m_ptr      = (m_cli + 1) % N;
      m_inflight = 0;
      m_resp     = 1;
      if (e_ops < 64'hFFFF_FFFF) e_ops++;
    end else begin
      m_excl  = m_resp ? m_cli : -1;
      e_ready = '0;
      m_resp  = 0;
      m_cnt   = 0;
      for (int k = 0; k < N; k++) if (cli.req_i[k] && k != m_excl) m_cnt++;
      m_win = rr_choose(cli.req_i, m_excl, m_ptr);
      if (m_win >= 0) begin
        m_cli      = m_win;
        e_mode     = cli.mode_i[m_win];
        e_a        = cli.a_i[m_win*W +: W];
        e_b        = cli.b_i[m_win*W +: W];
        m_inflight = 1;
        if (m_cnt >= 2 && e_conf < 65535) e_conf++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk_i or negedge rst_i);
    model_step();
  end

  initial forever begin
    @(negedge clk_i);
    check("ready", 32'(cli.ready_o), 32'(e_ready));
    check("res", 32'(cli.res_o), 32'(e_res));
    check("busy", 32'(busy_o), 32'(m_inflight || m_resp));
    check("alu_mode", 32'(alu_mode_o), 32'(e_mode));
    check("alu_a", 32'(alu_a_o), 32'(e_a));
    check("alu_b", 32'(alu_b_o), 32'(e_b));
`ifdef ARB_STATS_EN
    check("ops_cnt", ops_cnt_o, e_ops[31:0]);
    check("conflict_cnt", 32'(conflict_cnt_o), e_conf[31:0]);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_op(int k, logic mode, logic [W-1:0] a, logic [W-1:0] b);
    cli.mode_i[k]       = mode;
    cli.a_i[k*W +: W]   = a;
    cli.b_i[k*W +: W]   = b;
    cli.req_i[k]        = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ready(output int k, output int cycles);
    k = -1;
    cycles = 0;
    while (k < 0 && cycles < 20) begin
      step();
      cycles++;
      for (int i = 0; i < N; i++) if (cli.ready_o[i]) k = i;
    end
    if (k < 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(string tag, int k, logic mode, logic [W-1:0] a,
                        logic [W-1:0] b, logic [W-1:0] exp);
    int got, cyc;
    set_op(k, mode, a, b);
    wait_ready(got, cyc);
    check({tag, "_idx"}, got, k);
    check({tag, "_res"}, 32'(cli.res_o), 32'(exp));
    cli.req_i[k] = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    cli.req_i = '0;
    step();
    step();
    rst_i = 1'b1;
  endtask

  initial begin
    int got, cyc, last, npulse, k2;
    rst_i      = 1'b0;
    cli.req_i  = '0;
    cli.mode_i = '0;
    cli.a_i    = '0;
    cli.b_i    = '0;
    step();
    step();
    check("rst_ready", 32'(cli.ready_o), 32'd0);
    check("rst_res", 32'(cli.res_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_alu_a", 32'(alu_a_o), 32'd0);
    rst_i = 1'b1;
    step();

    // 1: single add, latency
    set_op(0, 1'b1, 8'd20, 8'd22);
    wait_ready(got, cyc);
    check("t1_idx", got, 0);
    check("t1_lat", cyc, 2);
    check("t1_ready", 32'(cli.ready_o), 32'b0001);
    check("t1_res", 32'(cli.res_o), 32'd42);
    cli.req_i[0] = 1'b0;
    step();
    step();
    check("t1_idle", 32'(busy_o), 32'd0);
    check("t1_res_hold", 32'(cli.res_o), 32'd42);

    // 2: wraparound arithmetic
    run_op("t2_sub", 0, 1'b0, 8'd3, 8'd5, 8'hFE);
    run_op("t2_add", 1, 1'b1, 8'd200, 8'd100, 8'd44);

    // 3: all four requesting continuously
    do_reset();
    for (int k = 0; k < N; k++) set_op(k, 1'($urandom), 8'($urandom), 8'($urandom));
    npulse = 0;
    last = 0;
    cyc = 0;
    while (npulse < 8 && cyc < 40) begin
      step();
      cyc++;
      check("t3_busy", 32'(busy_o), 32'd1);
      if (cli.ready_o != '0) begin
        k2 = -1;
        for (int i = 0; i < N; i++) if (cli.ready_o[i]) k2 = i;
        check("t3_order", k2, npulse % N);
        if (npulse > 0) check("t3_gap", cyc - last, 2);
        last = cyc;
        npulse++;
      end
    end
    if (npulse < 8) check("t3_timeout", 32'(npulse), 32'd8);
    cli.req_i = '0;
    repeat (4) step();

    // 4: pointer wrap
    do_reset();
    run_op("t4_a", 2, 1'b1, 8'd1, 8'd2, 8'd3);
    run_op("t4_wrap", 2, 1'b0, 8'd10, 8'd4, 8'd6);
    set_op(0, 1'b1, 8'd7, 8'd7);
    set_op(2, 1'b1, 8'd1, 8'd1);
    wait_ready(got, cyc);
    check("t4_first", got, 0);
    check("t4_first_res", 32'(cli.res_o), 32'd14);
    cli.req_i[0] = 1'b0;
    wait_ready(got, cyc);
    check("t4_second", got, 2);
    check("t4_second_res", 32'(cli.res_o), 32'd2);
    cli.req_i[2] = 1'b0;
    repeat (3) step();

    // 5: reset during ISSUE
    do_reset();
    run_op("t5_pre", 2, 1'b1, 8'd9, 8'd1, 8'd10);
    set_op(3, 1'b1, 8'd5, 8'd5);
    step();
    check("t5_busy_issue", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check("t5_ready_rst", 32'(cli.ready_o), 32'd0);
    check("t5_busy_rst", 32'(busy_o), 32'd0);
    check("t5_res_rst", 32'(cli.res_o), 32'd0);
    check("t5_alu_rst", 32'(alu_a_o), 32'd0);
    step();
    check("t5_no_pulse", 32'(cli.ready_o), 32'd0);
    cli.req_i = '0;
    rst_i = 1'b1;
    set_op(1, 1'b1, 8'd1, 8'd2);
    set_op(3, 1'b1, 8'd3, 8'd4);
    wait_ready(got, cyc);
    check("t5_ptr0", got, 1);
    cli.req_i[1] = 1'b0;
    wait_ready(got, cyc);
    check("t5_next", got, 3);
    cli.req_i[3] = 1'b0;
    repeat (3) step();
    run_op("t5_c2", 2, 1'b0, 8'd0, 8'd1, 8'hFF);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      step();
      for (int k = 0; k < N; k++) begin
        if (cli.req_i[k] && cli.ready_o[k]) begin
          if ($urandom_range(1, 0) == 1) set_op(k, 1'($urandom), 8'($urandom), 8'($urandom));
          else cli.req_i[k] = 1'b0;
        end else if (cli.req_i[k]) begin
          if ($urandom_range(15, 0) == 0) cli.req_i[k] = 1'b0;
          else if ($urandom_range(3, 0) == 0) set_op(k, 1'($urandom), 8'($urandom), 8'($urandom));
        end else if ($urandom_range(2, 0) == 0) begin
          set_op(k, 1'($urandom), 8'($urandom), 8'($urandom));
        end
      end
    end
    cli.req_i = '0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
